// File: rtl/regfile_pkg.sv
// Shared defaults and address-width derivation for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned N_RD_DEF   = 2;

  // Address width for a register count; never narrower than one bit.
  function automatic int unsigned aw_of(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array: one pending-producer flag per register, set by reserve,
// cleared by write, with N_RD combinational lookup ports. Entry 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned N_RD  = N_RD_DEF,
  localparam int unsigned AW    = aw_of(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic                   clr_en,
  input  logic [AW-1:0]          clr_addr,
  input  logic [N_RD-1:0][AW-1:0] lk_addr,
  output logic [N_RD-1:0]        lk_busy_c
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Set after clear so a same-address reserve wins over the write.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    lk_busy_c = '0;
    for (int unsigned p = 0; p < N_RD; p++) begin
      lk_busy_c[p] = busy_q[lk_addr[p]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard, registered reads and r0 = 0.
// Define REGFILE_MP_BYPASS_EN for write-first forwarding; default is read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  parameter  int unsigned N_RD   = N_RD_DEF,
  localparam int unsigned AW     = aw_of(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_RD-1:0][AW-1:0]    rd_addr,
  output logic [N_RD-1:0][DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]            rd_busy,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr
);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;
  logic [N_RD-1:0][DATA_W-1:0]  rd_data_q;
  logic [N_RD-1:0][DATA_W-1:0]  rd_data_d;
  logic [N_RD-1:0]              rd_busy_q;
  logic [N_RD-1:0]              rd_busy_d;
  logic [N_RD-1:0]              lk_busy_c;
  logic                         wr_live_c;

  assign wr_live_c = wr_en && (wr_addr != '0);

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .N_RD  (N_RD)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (rsv_en),
    .set_addr  (rsv_addr),
    .clr_en    (wr_en),
    .clr_addr  (wr_addr),
    .lk_addr   (rd_addr),
    .lk_busy_c (lk_busy_c)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_live_c) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  // Per-port read; a same-cycle write to the addressed register is forwarded
  // only in the bypass build, where busy reflects reserve-wins.
  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int unsigned p = 0; p < N_RD; p++) begin
      rd_data_d[p] = regs_q[rd_addr[p]];
      rd_busy_d[p] = lk_busy_c[p];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_live_c && (rd_addr[p] == wr_addr)) begin
        rd_data_d[p] = wr_data;
        rd_busy_d[p] = rsv_en && (rsv_addr == wr_addr);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule
